// File: rtl/arb_fifo_drain.sv
// arb_fifo_drain: pops tagged arbiter entries from the slave FIFO
// and presents them to the engine, tracking per-source bursts.
module arb_fifo_drain #(
  parameter int DW        = 32,
  parameter int BURST_LEN = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           fifo_empty,
  output logic           fifo_rd_en,
  input  logic [DW+10:0] fifo_rd_data,
  output logic           eng_valid,
  input  logic           eng_ready,
  output logic [DW-1:0]  eng_data,
  output logic [1:0]     eng_mode,
  output logic [7:0]     eng_proc_val,
  output logic           eng_src,
  output logic           mstr0_cmplt,
  output logic           mstr1_cmplt,
  input  logic           mstr0_cmplt_ack,
  input  logic           mstr1_cmplt_ack,
  output logic           drop_err
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  typedef struct packed {
    logic          src;
    logic [1:0]    mode;
    logic [7:0]    proc_val;
    logic [DW-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT
  } state_t;

  state_t  state;
  state_t  state_nx;
  entry_t  ent;
  logic    accept;
  logic    is_drop;
  logic    hit0;
  logic    hit1;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  assign ent     = fifo_rd_data;
  assign accept  = eng_valid && eng_ready;
  assign is_drop = (ent.mode == 2'b00);
  assign hit0    = accept && !eng_src && (cnt0 == LAST);
  assign hit1    = accept &&  eng_src && (cnt1 == LAST);

  always_comb begin
    state_nx   = state;
    fifo_rd_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nx   = FETCH;
        end
      end
      FETCH: begin
        state_nx = is_drop ? IDLE : PRESENT;
      end
      PRESENT: begin
        if (eng_ready) begin
          if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            state_nx   = FETCH;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // no pop may be issued while reset is held
    if (!rst_n) fifo_rd_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      eng_valid    <= 1'b0;
      eng_data     <= '0;
      eng_mode     <= '0;
      eng_proc_val <= '0;
      eng_src      <= 1'b0;
      drop_err     <= 1'b0;
    end else begin
      state    <= state_nx;
      drop_err <= (state == FETCH) && is_drop;
      if (state == FETCH) begin
        eng_data     <= ent.data;
        eng_mode     <= ent.mode;
        eng_proc_val <= ent.proc_val;
        eng_src      <= ent.src;
        eng_valid    <= !is_drop;
      end else if (accept) begin
        eng_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0        <= '0;
      cnt1        <= '0;
      mstr0_cmplt <= 1'b0;
      mstr1_cmplt <= 1'b0;
    end else begin
      if (accept && !eng_src) begin
        cnt0 <= (cnt0 == LAST) ? '0 : cnt0 + 1'b1;
      end
      if (accept && eng_src) begin
        cnt1 <= (cnt1 == LAST) ? '0 : cnt1 + 1'b1;
      end
      // a completing accept beats a same-cycle ack
      if (hit0) begin
        mstr0_cmplt <= 1'b1;
      end else if (mstr0_cmplt_ack) begin
        mstr0_cmplt <= 1'b0;
      end
      if (hit1) begin
        mstr1_cmplt <= 1'b1;
      end else if (mstr1_cmplt_ack) begin
        mstr1_cmplt <= 1'b0;
      end
    end
  end

endmodule

// File: doc/arb_fifo_drain.md
# arb_fifo_drain

Read-side counterpart of the two-slave arbiter. It pops the tagged entries the arbiter writes into the shared slave FIFO and presents them to the processing engine over a valid/ready handshake. It counts accepted words per source and raises a per-source completion level, mstr0_cmplt / mstr1_cmplt, which the arbiter uses to stop granting that source.

## Interface
- DW, 32, data word width; must match the arbiter's slvx_data.
- BURST_LEN, 64, words per source burst before completion; legal range 1..65535.
- FIFO entry format, fixed: {src[0], mode[1:0], proc_val[7:0], data[DW-1:0]}, DW+11 bits total.
- clk  in  1  sole clock; every flop updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- fifo_empty  in  1  FIFO has no entries.
- fifo_rd_en  out  1  pop request; the entry appears on fifo_rd_data one cycle later.
- fifo_rd_data  in  DW+11  popped entry.
- eng_valid  out  1  engine word valid.
- eng_ready  in  1  engine accepts the word.
- eng_data  out  DW  data field.
- eng_mode  out  2  mode field.
- eng_proc_val  out  8  proc_val field.
- eng_src  out  1  source tag: 0 = slave0, 1 = slave1.
- mstr0_cmplt  out  1  source 0 burst complete; level output.
- mstr1_cmplt  out  1  source 1 burst complete; level output.
- mstr0_cmplt_ack  in  1  clears mstr0_cmplt.
- mstr1_cmplt_ack  in  1  clears mstr1_cmplt.
- drop_err  out  1  one-cycle pulse: an entry with mode 2'b00 was discarded.

## Operation
- FSM states:
  - IDLE: if !fifo_empty, assert fifo_rd_en for 1 cycle, go to FETCH.
  - FETCH: capture fifo_rd_data into the output register.
    - mode != 2'b00: set eng_valid, go to PRESENT.
    - mode == 2'b00: do not present; pulse drop_err; go to IDLE.
  - PRESENT: hold all eng_* outputs stable while eng_valid && !eng_ready.
    - On accept (eng_ready), if !fifo_empty: assert fifo_rd_en in the same cycle, go to FETCH.
    - On accept, if fifo_empty: go to IDLE.
- fifo_rd_en is asserted only in IDLE or in an accepting PRESENT cycle, and only when fifo_empty == 0. It is never asserted in FETCH, and at most one pop is outstanding.
- Counters cnt0 and cnt1 are each $clog2(BURST_LEN+1) bits. They increment only on an accept (eng_valid && eng_ready) with the matching eng_src.
  - On an accept with cnt == BURST_LEN-1: cnt wraps to 0 and the matching mstrX_cmplt is set to 1.
  - BURST_LEN == 1: every accepted word sets cmplt.
- mstrX_cmplt stays high until the matching mstrX_cmplt_ack. If set and ack occur in the same cycle, set wins and the output stays 1.
- Words from a source whose cmplt is high are still dispatched and counted normally; no blocking in this block.
- Dropped entries (mode 00) never increment a counter.

## Timing
- Reset (rst_n low at a clock edge) drives:
  - state to IDLE;
  - fifo_rd_en, eng_valid, mstr0_cmplt, mstr1_cmplt, drop_err to 0;
  - eng_data, eng_mode, eng_proc_val, eng_src to 0;
  - cnt0, cnt1 to 0.
- Reset mid-operation: a popped entry in flight is lost; the FIFO is expected to be reset together with this block.
- Latency:
  - fifo_rd_en in cycle N gives eng_valid high in cycle N+2 (N+1 is FETCH; the register loads at the end of N+1).
  - Best-case throughput is one word per 2 cycles.
- cmplt rises in the cycle after the accepting edge of the final burst word.
- drop_err is high in the cycle after FETCH.
- eng_ready is ignored while eng_valid == 0.

## Test plan
- Single entry: source 0, mode 2'b01, proc_val 8'h5A, data 32'hDEADBEEF, eng_ready tied high.
  - Required: one fifo_rd_en pulse; eng_valid for exactly 1 cycle, 2 cycles after the pop; fields match; eng_src = 0.
- Backpressure: eng_ready low for 5 cycles while valid, with 3 entries queued.
  - Required: eng_* held stable throughout; no fifo_rd_en during the stall; all 3 words delivered in order.
- Burst completion with BURST_LEN = 4: 4 source-1 words accepted.
  - Required: mstr1_cmplt rises after the 4th accept and holds until mstr1_cmplt_ack; cnt1 returns to 0; mstr0_cmplt stays 0.
- Simultaneous set and ack: assert mstr0_cmplt_ack in the same cycle as the accept that completes a source-0 burst.
  - Required: mstr0_cmplt stays 1.
- Drop: entry with mode 2'b00.
  - Required: no eng_valid; one drop_err pulse; counters unchanged; the next valid entry is delivered normally.
- Reset mid-burst: assert rst_n = 0 while in PRESENT with cnt0 = 2.
  - Required: at the next edge, eng_valid = 0 and cnt0 = 0, with every other output at its reset value.
